// File: rtl/game_pkg.sv
// game_pkg: shared state, BCD digit type and constants for the game-flow controller
package game_pkg;
  typedef enum logic [2:0] {IDLE, INTRO, LAUNCH, FLYING, DUCK_DONE, ROUND_END, GAME_OVER} state_t;
  typedef logic [3:0] bcd_t;
  localparam bcd_t BCD_MAX = 4'd9;
endpackage

// File: rtl/bcd_counter.sv
// bcd_counter: multi-digit BCD up-counter that either saturates at all 9s or wraps to a preset
module bcd_counter import game_pkg::*; #(
  parameter int DIGITS = 4,
  parameter bit SATURATE = 1'b1,
  parameter int WRAP_TO = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inc,
  input  logic                clr,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  output logic [4*DIGITS-1:0] bcd
);
  localparam logic [4*DIGITS-1:0] WRAP = WRAP_TO[4*DIGITS-1:0];
  logic [4*DIGITS-1:0] nxt;
  logic [DIGITS:0] c;
  assign c[0] = 1'b1;
  for (genvar i = 0; i < DIGITS; i++) begin : g_d
    bcd_t d;
    logic top;
    assign d = bcd[4*i+:4];
    assign top = d == BCD_MAX;
    assign nxt[4*i+:4] = c[i] ? (top ? 4'd0 : d + 4'd1) : d;
    assign c[i+1] = c[i] & top;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) bcd <= '0;
    else if (clr) bcd <= '0;
    else if (load) bcd <= load_val;
    else if (inc) bcd <= c[DIGITS] ? (SATURATE ? bcd : WRAP) : nxt;
endmodule

// File: rtl/ctl_game.sv
// ctl_game: rounds/ducks/ammo game-flow FSM driving duck launches, BCD scoreboard and overlay flags
module ctl_game import game_pkg::*; #(
  parameter int DUCKS_PER_ROUND = 10,
  parameter int AMMO_PER_DUCK = 3,
  parameter int HITS_TO_PASS = 6,
  parameter int SCORE_DIGITS = 4,
  parameter int INTRO_FRAMES = 120,
  parameter int FLY_TIMEOUT_FRAMES = 600
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      new_frame,
  input  logic                      game_start,
  input  logic                      pause,
  input  logic                      shot_fired,
  input  logic                      hit,
  input  logic                      duck_gone,
  output logic                      duck_launch,
  output logic                      duck_escape,
  output logic [4*SCORE_DIGITS-1:0] score_bcd,
  output logic [3:0]                ammo_bcd,
  output logic [7:0]                round_bcd,
  output logic [3:0]                hits_in_round,
  output logic                      no_ammo,
  output logic                      paused,
  output logic                      looser,
  output logic                      game_over
);
  localparam int FMAX = INTRO_FRAMES > FLY_TIMEOUT_FRAMES ? INTRO_FRAMES : FLY_TIMEOUT_FRAMES;
  localparam int FW = $clog2(FMAX + 1);
  state_t state;
  logic [FW-1:0] fcnt;
  logic [3:0] ducks, ammo_n;
  logic gone_pend, frozen, gone, frame_end, score_inc, round_inc;
  assign frozen = pause && (state == INTRO || state == FLYING || state == DUCK_DONE);
  assign gone = duck_gone || gone_pend;
  assign ammo_n = shot_fired && ammo_bcd != 4'd0 ? ammo_bcd - 4'd1 : ammo_bcd;
  assign frame_end = new_frame && fcnt == FW'(state == INTRO ? INTRO_FRAMES - 1 : FLY_TIMEOUT_FRAMES - 1);
  assign score_inc = !game_start && !frozen && state == FLYING && !gone && hit;
  assign round_inc = !game_start && state == ROUND_END && hits_in_round >= 4'(HITS_TO_PASS);
  bcd_counter #(.DIGITS(SCORE_DIGITS), .SATURATE(1'b1), .WRAP_TO(0)) u_score (
    .clk(clk), .rst(rst), .inc(score_inc), .clr(game_start), .load(1'b0), .load_val('0), .bcd(score_bcd)
  );
  bcd_counter #(.DIGITS(2), .SATURATE(1'b0), .WRAP_TO(1)) u_round (
    .clk(clk), .rst(rst), .inc(round_inc), .clr(1'b0), .load(game_start), .load_val(8'h01), .bcd(round_bcd)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      fcnt <= '0;
      ducks <= '0;
      gone_pend <= 1'b0;
      duck_launch <= 1'b0;
      duck_escape <= 1'b0;
      ammo_bcd <= '0;
      hits_in_round <= '0;
      no_ammo <= 1'b0;
      paused <= 1'b0;
      looser <= 1'b0;
      game_over <= 1'b0;
    end else begin
      paused <= pause && state != IDLE && state != GAME_OVER;
      duck_launch <= 1'b0;
      if (game_start) begin
        state <= INTRO;
        fcnt <= '0;
        ducks <= '0;
        gone_pend <= 1'b0;
        duck_escape <= 1'b0;
        ammo_bcd <= '0;
        hits_in_round <= '0;
        no_ammo <= 1'b0;
        looser <= 1'b0;
        game_over <= 1'b0;
      end else if (frozen) gone_pend <= gone;
      // an early departure in FLYING takes the same exit as a finished duck
      else if ((state == FLYING || state == DUCK_DONE) && gone) begin
        gone_pend <= 1'b0;
        duck_escape <= 1'b0;
        no_ammo <= 1'b0;
        ducks <= ducks + 4'd1;
        if (ducks + 4'd1 == 4'(DUCKS_PER_ROUND)) state <= ROUND_END;
        else begin
          state <= LAUNCH;
          duck_launch <= 1'b1;
          ammo_bcd <= 4'(AMMO_PER_DUCK);
          fcnt <= '0;
        end
      end else
        case (state)
          INTRO:
            if (frame_end) begin
              state <= LAUNCH;
              duck_launch <= 1'b1;
              ammo_bcd <= 4'(AMMO_PER_DUCK);
              fcnt <= '0;
              gone_pend <= 1'b0;
            end else if (new_frame) fcnt <= fcnt + 1'b1;
          LAUNCH: state <= FLYING;
          FLYING: begin
            if (new_frame) fcnt <= fcnt + 1'b1;
            ammo_bcd <= ammo_n;
            no_ammo <= ammo_n == 4'd0;
            if (hit) begin
              hits_in_round <= hits_in_round + 4'd1;
              state <= DUCK_DONE;
            end else if (ammo_n == 4'd0 || frame_end) begin
              duck_escape <= 1'b1;
              state <= DUCK_DONE;
            end
          end
          ROUND_END:
            if (round_inc) begin
              state <= INTRO;
              hits_in_round <= '0;
              ducks <= '0;
              fcnt <= '0;
            end else begin
              state <= GAME_OVER;
              looser <= 1'b1;
              game_over <= 1'b1;
            end
          default: ;
        endcase
    end
endmodule

// File: tb/tb_ctl_game.sv
// tb_ctl_game: scoreboard bench; stimulus queues expected output snapshots, a monitor compares them
module tb_ctl_game;
  typedef struct {string name; int id; logic [37:0] v;} exp_t;
  logic clk = 0, rst = 1;
  logic nf1 = 0, gs1 = 0, p1 = 0, sh1 = 0, ht1 = 0, dg1 = 0;
  logic nf2 = 0, gs2 = 0, sh2 = 0, ht2 = 0, dg2 = 0, p2 = 0;
  logic la1, es1, na1, pa1, lo1, go1, la2, es2, na2, pa2, lo2, go2;
  logic [15:0] sc1;
  logic [3:0] sc2, am1, am2, hi1, hi2;
  logic [7:0] rd1, rd2;
  logic chk_req = 0;
  exp_t q1[$], qc[$];
  int n_chk = 0, n_fail = 0;
  int sc, rd, hr, dk, am;
  always #5 clk = ~clk;
  ctl_game d1 (
    .clk(clk), .rst(rst), .new_frame(nf1), .game_start(gs1), .pause(p1), .shot_fired(sh1), .hit(ht1),
    .duck_gone(dg1), .duck_launch(la1), .duck_escape(es1), .score_bcd(sc1), .ammo_bcd(am1),
    .round_bcd(rd1), .hits_in_round(hi1), .no_ammo(na1), .paused(pa1), .looser(lo1), .game_over(go1)
  );
  ctl_game #(.DUCKS_PER_ROUND(1), .AMMO_PER_DUCK(2), .HITS_TO_PASS(1), .SCORE_DIGITS(1),
             .INTRO_FRAMES(1), .FLY_TIMEOUT_FRAMES(4)) d2 (
    .clk(clk), .rst(rst), .new_frame(nf2), .game_start(gs2), .pause(p2), .shot_fired(sh2), .hit(ht2),
    .duck_gone(dg2), .duck_launch(la2), .duck_escape(es2), .score_bcd(sc2), .ammo_bcd(am2),
    .round_bcd(rd2), .hits_in_round(hi2), .no_ammo(na2), .paused(pa2), .looser(lo2), .game_over(go2)
  );
  wire [37:0] snap1 = {la1, es1, sc1, am1, rd1, hi1, na1, pa1, lo1, go1};
  wire [37:0] snap2 = {la2, es2, 12'd0, sc2, am2, rd2, hi2, na2, pa2, lo2, go2};
  function automatic logic [37:0] mk(bit la, bit es, int s, int a, int r, int h, bit na, bit pa, bit lo, bit go);
    return {la, es, 4'(s / 1000 % 10), 4'(s / 100 % 10), 4'(s / 10 % 10), 4'(s % 10), 4'(a),
            4'(r / 10 % 10), 4'(r % 10), 4'(h), na, pa, lo, go};
  endfunction
  function automatic void cmp(string name, logic [37:0] act, logic [37:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, want);
    end
  endfunction
  always @(negedge clk) begin
    exp_t e;
    if (la1) begin
      if (q1.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL launch_unexpected: got duck_launch=1 expected 0");
      end else begin
        e = q1.pop_front();
        cmp(e.name, snap1, e.v);
      end
    end
    if (chk_req && qc.size() != 0) begin
      e = qc.pop_front();
      cmp(e.name, e.id == 1 ? snap1 : snap2, e.v);
    end
  end
  task automatic push_chk(input int id, input string name, input logic [37:0] v);
    qc.push_back('{name, id, v});
    chk_req = 1;
    @(negedge clk);
    #1 chk_req = 0;
  endtask
  task automatic cyc(input bit nf = 0, input bit gs = 0, input bit sh = 0, input bit ht = 0, input bit dg = 0);
    {nf1, gs1, sh1, ht1, dg1} = {nf, gs, sh, ht, dg};
    @(posedge clk);
    #1 {nf1, gs1, sh1, ht1, dg1} = 5'b0;
  endtask
  task automatic cyc2(input bit nf = 0, input bit gs = 0, input bit ht = 0, input bit dg = 0);
    {nf2, gs2, ht2, dg2} = {nf, gs, ht, dg};
    @(posedge clk);
    #1 {nf2, gs2, ht2, dg2} = 4'b0;
  endtask
  task automatic push_launch();
    am = 3;
    q1.push_back('{"launch", 1, mk(1, 0, sc, 3, rd, hr, 0, 0, 0, 0)});
  endtask
  task automatic intro();
    repeat (119) cyc(1);
    push_launch();
    cyc(1);
    cyc();
  endtask
  task automatic next_duck();
    dk++;
    if (dk < 10) begin
      push_launch();
      cyc(0, 0, 0, 0, 1);
      cyc();
    end else begin
      cyc(0, 0, 0, 0, 1);
      cyc();
      if (hr >= 6) begin
        rd = rd == 99 ? 1 : rd + 1;
        hr = 0;
        dk = 0;
        push_chk(1, "round_pass", mk(0, 0, sc, am, rd, 0, 0, 0, 0, 0));
      end else push_chk(1, "round_fail", mk(0, 0, sc, am, rd, hr, 0, 0, 1, 1));
    end
  endtask
  task automatic hit_duck();
    cyc(0, 0, 0, 1);
    sc++;
    hr++;
    next_duck();
  endtask
  task automatic start();
    cyc(0, 1);
    sc = 0; rd = 1; hr = 0; dk = 0; am = 0;
    push_chk(1, "start", mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (3) @(posedge clk);
    #1 push_chk(1, "reset", 38'd0);
    rst = 0;
    start();
    intro();
    push_chk(1, "launch_once", mk(0, 0, 0, 3, 1, 0, 0, 0, 0, 0));
    cyc(0, 0, 1); push_chk(1, "shot1", mk(0, 0, 0, 2, 1, 0, 0, 0, 0, 0));
    cyc(0, 0, 1); push_chk(1, "shot2", mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
    cyc(0, 0, 1); push_chk(1, "shot3", mk(0, 1, 0, 0, 1, 0, 1, 0, 0, 0));
    cyc(0, 0, 1); push_chk(1, "shot4", mk(0, 1, 0, 0, 1, 0, 1, 0, 0, 0));
    next_duck();
    cyc(0, 0, 1);
    cyc(0, 0, 1);
    cyc(0, 0, 1, 1);
    sc = 1; hr = 1; am = 0;
    push_chk(1, "shot_hit", mk(0, 0, 1, 0, 1, 1, 1, 0, 0, 0));
    next_duck();
    repeat (5) hit_duck();
    repeat (3) next_duck();
    intro();
    p1 = 1;
    cyc();
    repeat (700) cyc(1, 0, 1, 1);
    push_chk(1, "pause_hold", mk(0, 0, 6, 3, 2, 0, 0, 1, 0, 0));
    p1 = 0;
    cyc();
    repeat (599) cyc(1);
    push_chk(1, "no_timeout", mk(0, 0, 6, 3, 2, 0, 0, 0, 0, 0));
    cyc(1);
    push_chk(1, "timeout", mk(0, 1, 6, 3, 2, 0, 0, 0, 0, 0));
    p1 = 1;
    cyc(0, 0, 0, 0, 1);
    push_chk(1, "gone_latched", mk(0, 1, 6, 3, 2, 0, 0, 1, 0, 0));
    p1 = 0;
    dk = 1;
    push_launch();
    cyc();
    cyc();
    repeat (5) hit_duck();
    repeat (4) next_duck();
    start();
    intro();
    cyc(0, 0, 1);
    rst = 1;
    push_chk(1, "async_rst", 38'd0);
    @(posedge clk);
    #1 rst = 0;
    cyc2(0, 1);
    push_chk(2, "d2_start", mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    for (int n = 1; n <= 99; n++) begin
      cyc2(1);
      cyc2();
      cyc2(0, 0, 1);
      cyc2(0, 0, 0, 1);
      cyc2();
      if (n == 9 || n == 10 || n == 98 || n == 99)
        push_chk(2, "d2_round", mk(0, 0, n > 9 ? 9 : n, 2, n == 99 ? 1 : n + 1, 0, 0, 0, 0, 0));
    end
    @(negedge clk);
    n_chk++;
    if (q1.size() != 0) begin
      n_fail++;
      $display("FAIL launch_missing: got %0d pending expected 0", q1.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
